// File: rtl/alu_mc_if.sv
// ALU request/response bundle between the phase controller and the multi-cycle ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32,
    parameter int DST_W = 3
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [DST_W-1:0] dst_in;
    logic             busy;
    logic             done;
    logic             wr_en;
    logic [WIDTH-1:0] result;
    logic [DST_W-1:0] dst_out;
    logic [3:0]       flags;
    logic             illegal;

    // Requester side: issues ops, observes completion.
    modport master (
        output start, op, a, b, dst_in,
        input  busy, done, wr_en, result, dst_out, flags, illegal
    );

    // ALU side.
    modport slave (
        input  start, op, a, b, dst_in,
        output busy, done, wr_en, result, dst_out, flags, illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, iterative 1-bit-per-cycle shifts.
// flags = {OF, CF, SF, ZF}, held until an op that updates them completes.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int DST_W = 3,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_CMP = 4'd2,  OP_AND = 4'd3,
        OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_NEG = 4'd6,  OP_NOT = 4'd7,
        OP_SLL = 4'd8,  OP_SLA = 4'd9,  OP_SRL = 4'd10, OP_SRA = 4'd11,
        OP_MOV = 4'd12
    } op_e;

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state, state_next;
    op_e              op_in;
    op_e              sh_op;
    logic [WIDTH-1:0] sh_reg;
    logic [SHW-1:0]   count;
    logic             sh_of;

    logic [WIDTH-1:0] result_q;
    logic [DST_W-1:0] dst_q;
    logic [3:0]       flags_q;
    logic             done_q, wr_en_q, illegal_q;

    logic             accept, is_shift, go_shift, last_step;
    logic [SHW-1:0]   shamt;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] c_res;
    logic [3:0]       c_flags;
    logic             c_wr, c_ill;

    logic [WIDTH-1:0] step_res;
    logic             step_cf, step_of;

    function automatic logic [3:0] mk_flags(input logic of, input logic cf,
                                            input logic [WIDTH-1:0] r);
        return {of, cf, r[WIDTH-1], (r == '0)};
    endfunction

    assign op_in     = op_e'(bus.op);
    assign shamt     = bus.b[SHW-1:0];
    assign accept    = (state == S_IDLE) && bus.start;
    assign is_shift  = op_in inside {OP_SLL, OP_SLA, OP_SRL, OP_SRA};
    assign go_shift  = accept && is_shift && (shamt != '0);
    assign last_step = (state == S_SHIFT) && (count == SHW'(1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state: stay IDLE for single-cycle ops, walk SHIFT until the final bit.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (prevents latches).
        state_next = state;
        case (state)
            S_IDLE:  if (go_shift)  state_next = S_SHIFT;
            S_SHIFT: if (last_step) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle result and flags from the live request; also covers shifts by zero.
    always_comb begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = {1'b0, bus.a} - {1'b0, bus.b};
        c_res   = result_q;
        c_flags = flags_q;
        c_wr    = 1'b0;
        c_ill   = 1'b0;
        case (op_in)
            OP_ADD: begin
                c_res   = sum[WIDTH-1:0];
                c_flags = mk_flags((bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                   (sum[WIDTH-1] != bus.a[WIDTH-1]),
                                   sum[WIDTH], sum[WIDTH-1:0]);
                c_wr    = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                // The extra top bit of the zero-extended difference is the borrow.
                c_flags = mk_flags((bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                   (diff[WIDTH-1] != bus.a[WIDTH-1]),
                                   diff[WIDTH], diff[WIDTH-1:0]);
                if (op_in == OP_SUB) begin
                    c_res = diff[WIDTH-1:0];
                    c_wr  = 1'b1;
                end
            end
            OP_AND: begin
                c_res   = bus.a & bus.b;
                c_flags = mk_flags(1'b0, 1'b0, bus.a & bus.b);
                c_wr    = 1'b1;
            end
            OP_OR: begin
                c_res   = bus.a | bus.b;
                c_flags = mk_flags(1'b0, 1'b0, bus.a | bus.b);
                c_wr    = 1'b1;
            end
            OP_XOR: begin
                c_res   = bus.a ^ bus.b;
                c_flags = mk_flags(1'b0, 1'b0, bus.a ^ bus.b);
                c_wr    = 1'b1;
            end
            OP_NEG: begin
                c_res   = '0 - bus.a;
                c_flags = mk_flags(bus.a == MIN_VAL, bus.a != '0, '0 - bus.a);
                c_wr    = 1'b1;
            end
            OP_NOT: begin
                c_res = ~bus.a;
                c_wr  = 1'b1;
            end
            OP_MOV: begin
                c_res = bus.b;
                c_wr  = 1'b1;
            end
            OP_SLL, OP_SLA, OP_SRL, OP_SRA: begin
                // Shift by zero: operand passes through, carry is kept.
                c_res   = bus.a;
                c_flags = mk_flags(1'b0, flags_q[2], bus.a);
                c_wr    = 1'b1;
            end
            default: c_ill = 1'b1;
        endcase
    end

    // One shift step on the working register; SLA overflow is sticky across steps.
    always_comb begin
        step_res = sh_reg;
        step_cf  = 1'b0;
        case (sh_op)
            OP_SLL, OP_SLA: begin
                step_res = {sh_reg[WIDTH-2:0], 1'b0};
                step_cf  = sh_reg[WIDTH-1];
            end
            OP_SRL: begin
                step_res = {1'b0, sh_reg[WIDTH-1:1]};
                step_cf  = sh_reg[0];
            end
            OP_SRA: begin
                step_res = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
                step_cf  = sh_reg[0];
            end
            default: begin
                step_res = sh_reg;
                step_cf  = 1'b0;
            end
        endcase
        step_of = sh_of || ((sh_op == OP_SLA) && (step_res[WIDTH-1] != sh_reg[WIDTH-1]));
    end

    // Datapath: accept requests, iterate shifts, publish result/flags with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            dst_q     <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            sh_reg    <= '0;
            count     <= '0;
            sh_op     <= OP_ADD;
            sh_of     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            if (accept) begin
                dst_q <= bus.dst_in;
                if (go_shift) begin
                    sh_reg <= bus.a;
                    count  <= shamt;
                    sh_op  <= op_in;
                    sh_of  <= 1'b0;
                end else begin
                    result_q  <= c_res;
                    flags_q   <= c_flags;
                    done_q    <= 1'b1;
                    wr_en_q   <= c_wr;
                    illegal_q <= c_ill;
                end
            end else if (state == S_SHIFT) begin
                sh_reg <= step_res;
                count  <= count - SHW'(1);
                sh_of  <= step_of;
                if (last_step) begin
                    result_q <= step_res;
                    flags_q  <= mk_flags(step_of, step_cf, step_res);
                    done_q   <= 1'b1;
                    wr_en_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.busy    = (state == S_SHIFT);
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.result  = result_q;
    assign bus.dst_out = dst_q;
    assign bus.flags   = flags_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32: vector table for single-cycle ops,
// hand sequences for shifts, busy-time requests, back-to-back issue and reset abort.
module tb_alu_mc;
    localparam int WIDTH = 32;
    localparam int DST_W = 3;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_CMP = 4'd2,  OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_NEG = 4'd6,  OP_NOT = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8,  OP_SLA = 4'd9,  OP_SRL = 4'd10, OP_SRA = 4'd11;
    localparam logic [3:0] OP_MOV = 4'd12;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(WIDTH), .DST_W(DST_W)) bus ();

    alu_mc #(.WIDTH(WIDTH), .DST_W(DST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  dst;
        logic [31:0] res;
        logic [3:0]  flg;   // {OF,CF,SF,ZF}
        logic        wr;
        logic        ill;
    } vec_t;

    vec_t vecs[18];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] dst);
        bus.start  = s;
        bus.op     = op;
        bus.a      = a;
        bus.b      = b;
        bus.dst_in = dst;
    endtask

    // Issue a shift, optionally poke an ADD during the first busy cycle, wait for done.
    task automatic run_shift(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] dst, input int exp_lat,
                             input logic [31:0] exp_res, input logic [3:0] exp_flg,
                             input bit poke_add);
        int lat;
        int busy_cnt;
        drive(1'b1, op, a, b, dst);
        tick();
        lat      = 1;
        busy_cnt = 0;
        while (!bus.done && lat < 80) begin
            if (bus.busy) busy_cnt++;
            if (poke_add && lat == 1) drive(1'b1, OP_ADD, 32'h1, 32'h1, 3'd7);
            else                      drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
            tick();
            lat++;
        end
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        check({name, " latency"},     32'(lat),      32'(exp_lat));
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({name, " busy at done"}, bus.busy,     32'd0);
        check({name, " result"},      bus.result,    exp_res);
        check({name, " flags"},       bus.flags,     exp_flg);
        check({name, " wr_en"},       bus.wr_en,     32'd1);
        check({name, " dst_out"},     bus.dst_out,   dst);
        tick();
        check({name, " single done"}, bus.done,      32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Expected values hand-computed in issue order; flags carry over between rows.
        vecs[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 3'd1, 32'h00000000, 4'b0101, 1'b1, 1'b0};
        vecs[1]  = '{OP_SUB, 32'h80000000, 32'h00000001, 3'd2, 32'h7FFFFFFF, 4'b1000, 1'b1, 1'b0};
        vecs[2]  = '{OP_CMP, 32'h00000003, 32'h00000005, 3'd3, 32'h7FFFFFFF, 4'b0110, 1'b0, 1'b0};
        vecs[3]  = '{OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 3'd4, 32'h00000000, 4'b0001, 1'b1, 1'b0};
        vecs[4]  = '{OP_OR,  32'h12340000, 32'h00005678, 3'd5, 32'h12345678, 4'b0000, 1'b1, 1'b0};
        vecs[5]  = '{OP_XOR, 32'h80000000, 32'h00000001, 3'd6, 32'h80000001, 4'b0010, 1'b1, 1'b0};
        vecs[6]  = '{OP_NEG, 32'h00000001, 32'h00000000, 3'd7, 32'hFFFFFFFF, 4'b0110, 1'b1, 1'b0};
        vecs[7]  = '{OP_NEG, 32'h80000000, 32'h00000000, 3'd0, 32'h80000000, 4'b1110, 1'b1, 1'b0};
        vecs[8]  = '{OP_SLL, 32'h80000000, 32'h00000000, 3'd1, 32'h80000000, 4'b0110, 1'b1, 1'b0};
        vecs[9]  = '{OP_NEG, 32'h00000000, 32'h00000000, 3'd2, 32'h00000000, 4'b0001, 1'b1, 1'b0};
        vecs[10] = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 3'd3, 32'h80000000, 4'b1010, 1'b1, 1'b0};
        vecs[11] = '{OP_NOT, 32'h0000FFFF, 32'h00000000, 3'd4, 32'hFFFF0000, 4'b1010, 1'b1, 1'b0};
        vecs[12] = '{OP_MOV, 32'h00000000, 32'hDEADBEEF, 3'd5, 32'hDEADBEEF, 4'b1010, 1'b1, 1'b0};
        vecs[13] = '{4'd13,  32'h11111111, 32'h22222222, 3'd6, 32'hDEADBEEF, 4'b1010, 1'b0, 1'b1};
        // Shift amount comes from b[4:0] only, so b=32 is a shift by zero.
        vecs[14] = '{OP_SRA, 32'h00000001, 32'h00000020, 3'd7, 32'h00000001, 4'b0000, 1'b1, 1'b0};
        vecs[15] = '{OP_SUB, 32'h00000005, 32'h00000005, 3'd0, 32'h00000000, 4'b0001, 1'b1, 1'b0};
        vecs[16] = '{OP_SUB, 32'h00000003, 32'h00000005, 3'd1, 32'hFFFFFFFE, 4'b0110, 1'b1, 1'b0};
        vecs[17] = '{OP_ADD, 32'h80000000, 32'h80000000, 3'd2, 32'h00000000, 4'b1101, 1'b1, 1'b0};

        // Reset state.
        rst = 1'b1;
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        tick();
        tick();
        check("reset result",  bus.result,  32'd0);
        check("reset flags",   bus.flags,   32'd0);
        check("reset dst_out", bus.dst_out, 32'd0);
        check("reset busy",    bus.busy,    32'd0);
        check("reset done",    bus.done,    32'd0);
        check("reset wr_en",   bus.wr_en,   32'd0);
        check("reset illegal", bus.illegal, 32'd0);
        rst = 1'b0;
        tick();

        // Single-cycle vectors, issued back to back.
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst);
            tick();
            check($sformatf("vec%0d done", i),    bus.done,    32'd1);
            check($sformatf("vec%0d result", i),  bus.result,  vecs[i].res);
            check($sformatf("vec%0d flags", i),   bus.flags,   32'(vecs[i].flg));
            check($sformatf("vec%0d wr_en", i),   bus.wr_en,   32'(vecs[i].wr));
            check($sformatf("vec%0d illegal", i), bus.illegal, 32'(vecs[i].ill));
            check($sformatf("vec%0d dst_out", i), bus.dst_out, 32'(vecs[i].dst));
        end
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        tick();
        check("idle done", bus.done, 32'd0);

        // SRA by 5, with an ADD request during busy that must be ignored.
        run_shift("sra5", OP_SRA, 32'h80000010, 32'd5, 3'd5, 6, 32'hFC000000, 4'b0110, 1'b1);
        // SLA by 2: MSB flips on step 1 (OF); last bit shifted out is the 1 from 0x80000000.
        run_shift("sla2", OP_SLA, 32'h40000000, 32'd2, 3'd6, 3, 32'h00000000, 4'b1101, 1'b0);
        // Longest shift: SRL by 31, last bit out is 0.
        run_shift("srl31", OP_SRL, 32'h80000000, 32'd31, 3'd1, 32, 32'h00000001, 4'b0000, 1'b0);

        // Back-to-back ADD, XOR, NEG, then NOT keeps NEG's flags.
        drive(1'b1, OP_ADD, 32'd2, 32'd3, 3'd1);
        tick();
        check("b2b add done",   bus.done,    32'd1);
        check("b2b add result", bus.result,  32'd5);
        check("b2b add dst",    bus.dst_out, 32'd1);
        drive(1'b1, OP_XOR, 32'd5, 32'd5, 3'd2);
        tick();
        check("b2b xor done",   bus.done,    32'd1);
        check("b2b xor result", bus.result,  32'd0);
        check("b2b xor flags",  bus.flags,   32'b0001);
        check("b2b xor dst",    bus.dst_out, 32'd2);
        drive(1'b1, OP_NEG, 32'd5, 32'd0, 3'd3);
        tick();
        check("b2b neg done",   bus.done,    32'd1);
        check("b2b neg result", bus.result,  32'hFFFFFFFB);
        check("b2b neg flags",  bus.flags,   32'b0110);
        check("b2b neg dst",    bus.dst_out, 32'd3);
        drive(1'b1, OP_NOT, 32'd0, 32'd0, 3'd4);
        tick();
        check("not result", bus.result, 32'hFFFFFFFF);
        check("not flags",  bus.flags,  32'b0110);
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        tick();

        // Reset in the middle of a 10-bit SRL aborts it without done.
        begin
            int dones;
            drive(1'b1, OP_SRL, 32'hFFFFFFFF, 32'd10, 3'd6);
            tick();
            drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
            check("abort busy", bus.busy, 32'd1);
            tick();
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("abort busy after rst",   bus.busy,    32'd0);
            check("abort done after rst",   bus.done,    32'd0);
            check("abort result after rst", bus.result,  32'd0);
            check("abort flags after rst",  bus.flags,   32'd0);
            check("abort dst after rst",    bus.dst_out, 32'd0);
            check("abort wr_en after rst",  bus.wr_en,   32'd0);
            dones = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (bus.done) dones++;
            end
            check("abort no done", 32'(dones), 32'd0);
        end

        // Illegal op after a flag-setting ADD leaves result and flags alone.
        drive(1'b1, OP_ADD, 32'h7FFFFFFF, 32'h1, 3'd3);
        tick();
        check("pre-ill result", bus.result, 32'h80000000);
        drive(1'b1, 4'd14, 32'h5, 32'h6, 3'd4);
        tick();
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 3'd0);
        check("ill done",    bus.done,    32'd1);
        check("ill illegal", bus.illegal, 32'd1);
        check("ill wr_en",   bus.wr_en,   32'd0);
        check("ill result",  bus.result,  32'h80000000);
        check("ill flags",   bus.flags,   32'b1010);
        check("ill dst",     bus.dst_out, 32'd4);
        tick();
        check("ill pulse end", bus.illegal, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
